// File: rtl/cp0_pkg.sv
// Shared constants and field-packing helpers for the CP0 register file.
// Register indices, SR/Cause bit positions and the default processor ID.
package cp0_pkg;

    localparam logic [4:0] IDX_COUNT   = 5'd9;
    localparam logic [4:0] IDX_COMPARE = 5'd11;
    localparam logic [4:0] IDX_SR      = 5'd12;
    localparam logic [4:0] IDX_CAUSE   = 5'd13;
    localparam logic [4:0] IDX_EPC     = 5'd14;
    localparam logic [4:0] IDX_PRID    = 5'd15;

    localparam int BIT_IM_LO = 10;
    localparam int BIT_IM_HI = 15;
    localparam int BIT_EXL   = 1;
    localparam int BIT_IE    = 0;

    localparam logic [31:0] PRID_DEFAULT = 32'h4D49_5053;

    // IM and IP occupy the same bit window in SR and Cause respectively.
    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] v;
        v = '0;
        v[BIT_IM_HI:BIT_IM_LO] = im;
        v[BIT_EXL] = exl;
        v[BIT_IE] = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic [5:0] ip);
        logic [31:0] v;
        v = '0;
        v[BIT_IM_HI:BIT_IM_LO] = ip;
        return v;
    endfunction

endpackage

// File: rtl/cp0_regs_if.sv
// Controller <-> CP0 interface: mfc0/mtc0 access, exception entry/return,
// interrupt request and EPC back to the next-PC mux.
interface cp0_regs_if;
    logic [4:0]  a;
    logic [31:0] din;
    logic        we;
    logic [29:0] pc;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [29:0] epc;
    logic [31:0] dout;

    modport master (
        output a, din, we, pc, EXLSet, EXLClr,
        input  IntReq, epc, dout
    );

    modport slave (
        input  a, din, we, pc, EXLSet, EXLClr,
        output IntReq, epc, dout
    );
endinterface

// File: rtl/cp0_sync.sv
// Two-flop synchroniser for asynchronous level inputs, async active-low reset.
module cp0_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage1;

    // NOTE: non-blocking so both stages sample pre-edge values and form a real 2-deep pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end
endmodule

// File: rtl/cp0_regs.sv
// CP0 register file (SR, Cause, EPC, PrID) and interrupt request generation.
// Optional Count/Compare timer enabled by defining CP0_COUNT_EN.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = PRID_DEFAULT,
    parameter int          HW_IRQS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [HW_IRQS-1:0] HWInt,
    cp0_regs_if.slave          bus
);
    logic [HW_IRQS-1:0] im;
    logic               exl;
    logic               ie;
    logic [HW_IRQS-1:0] ip_sync;
    logic [HW_IRQS-1:0] ip;
    logic [29:0]        epc_q;

    logic wr_sr;
    logic wr_epc;

    assign wr_sr  = bus.we && (bus.a == IDX_SR);
    assign wr_epc = bus.we && (bus.a == IDX_EPC);

    cp0_sync #(.WIDTH(HW_IRQS)) u_hw_sync (
        .clk (clk),
        .rst (rst),
        .d   (HWInt),
        .q   (ip_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im <= '0;
            ie <= 1'b0;
        end else if (wr_sr) begin
            im <= bus.din[BIT_IM_HI:BIT_IM_LO];
            ie <= bus.din[BIT_IE];
        end
    end

    // Exception entry outranks an SR write, which outranks eret.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            exl <= 1'b0;
        else if (bus.EXLSet)
            exl <= 1'b1;
        else if (wr_sr)
            exl <= bus.din[BIT_EXL];
        else if (bus.EXLClr)
            exl <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            epc_q <= '0;
        else if (bus.EXLSet)
            epc_q <= bus.pc;
        else if (wr_epc)
            epc_q <= bus.din[31:2];
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        tip;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = bus.we && (bus.a == IDX_COUNT);
    assign wr_compare = bus.we && (bus.a == IDX_COMPARE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            compare <= '0;
            tip     <= 1'b0;
        end else begin
            count <= wr_count ? bus.din : count + 32'd1;
            if (wr_compare)
                compare <= bus.din;
            // Acknowledging via a Compare write wins over a coincident match.
            if (wr_compare)
                tip <= 1'b0;
            else if ((count == compare) && (compare != '0))
                tip <= 1'b1;
        end
    end

    // Timer interrupt joins IP[5] after the synchroniser: it is already synchronous.
    assign ip = ip_sync | {tip, {(HW_IRQS-1){1'b0}}};
`else
    assign ip = ip_sync;
`endif

    assign bus.IntReq = (|(ip & im)) & ie & ~exl;
    assign bus.epc    = epc_q;

    // NOTE: default assigned first so every path drives dout and no latch is inferred.
    always_comb begin
        bus.dout = '0;
        case (bus.a)
            IDX_SR:      bus.dout = pack_sr(im, exl, ie);
            IDX_CAUSE:   bus.dout = pack_cause(ip);
            IDX_EPC:     bus.dout = {epc_q, 2'b00};
            IDX_PRID:    bus.dout = PRID;
`ifdef CP0_COUNT_EN
            IDX_COUNT:   bus.dout = count;
            IDX_COMPARE: bus.dout = compare;
`endif
            default:     bus.dout = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cp0_regs;
    logic       clk;
    logic       rst;
    logic [5:0] HWInt;

    cp0_regs_if bus ();

    cp0_regs dut (
        .clk   (clk),
        .rst   (rst),
        .HWInt (HWInt),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: architectural register contents after each edge.
    logic [5:0]  m_im      = '0;
    logic        m_exl     = 1'b0;
    logic        m_ie      = 1'b0;
    logic [29:0] m_epc     = '0;
    logic [5:0]  m_hw_prev = '0;
    logic [5:0]  m_ip      = '0;
    logic [31:0] m_count   = '0;
    logic [31:0] m_compare = '0;
    logic        m_tip     = 1'b0;
    logic        m_hit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_im = '0; m_exl = 1'b0; m_ie = 1'b0; m_epc = '0;
            m_hw_prev = '0; m_ip = '0;
            m_count = '0; m_compare = '0; m_tip = 1'b0;
        end else begin
            // IP shows what HWInt was at the previous edge.
            m_ip = m_hw_prev;
            m_hw_prev = HWInt;
            // Effects applied from lowest to highest priority; the last one wins.
            if (bus.EXLClr) m_exl = 1'b0;
            if (bus.we && bus.a == 5'd12) begin
                m_im  = bus.din[15:10];
                m_exl = bus.din[1];
                m_ie  = bus.din[0];
            end
            if (bus.we && bus.a == 5'd14) m_epc = bus.din[31:2];
            if (bus.EXLSet) begin
                m_exl = 1'b1;
                m_epc = bus.pc;
            end
`ifdef CP0_COUNT_EN
            m_hit = (m_count == m_compare) && (m_compare != 0);
            m_count = (bus.we && bus.a == 5'd9) ? bus.din : m_count + 1;
            if (m_hit) m_tip = 1'b1;
            if (bus.we && bus.a == 5'd11) begin
                m_compare = bus.din;
                m_tip = 1'b0;
            end
`endif
        end
    end

    function automatic logic [5:0] exp_ip();
        return m_ip | (m_tip ? 6'b100000 : 6'b000000);
    endfunction

    function automatic logic exp_intreq();
        return ((exp_ip() & m_im) != 0) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        case (idx)
            5'd12: return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13: return {16'b0, exp_ip(), 10'b0};
            5'd14: return {m_epc, 2'b00};
            5'd15: return 32'h4D49_5053;
`ifdef CP0_COUNT_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("cyc_intreq", {31'b0, bus.IntReq}, {31'b0, exp_intreq()});
            check("cyc_epc", {2'b0, bus.epc}, {2'b0, m_epc});
            check("cyc_dout", bus.dout, exp_read(bus.a));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string name);
        bus.a = idx;
        #1;
        check(name, bus.dout, exp);
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        bus.we = 1'b1;
        bus.a = idx;
        bus.din = d;
        tick();
        bus.we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.a = '0; bus.din = '0; bus.we = 1'b0; bus.pc = '0;
        bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
        HWInt = '0;
        #1 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset values
        rd(5'd12, 32'h0, "rst_sr");
        check("rst_intreq", {31'b0, bus.IntReq}, 32'h0);
        tick();
        rd(5'd13, 32'h0, "rst_cause");
        tick();
        rd(5'd14, 32'h0, "rst_epc");
        tick();
        rd(5'd15, 32'h4D49_5053, "rst_prid");

`ifdef CP0_COUNT_EN
        tick();
        wr(5'd9, 32'h100);
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        repeat (5) tick();
        rd(5'd9, 32'd5, "cnt_at5");
        check("cnt_no_irq_yet", {31'b0, bus.IntReq}, 32'h0);
        tick();
        check("cnt_tip_irq", {31'b0, bus.IntReq}, 32'h1);
        rd(5'd13, 32'h0000_8000, "cnt_cause_tip");
        wr(5'd11, 32'd0);
        check("cnt_tip_cleared", {31'b0, bus.IntReq}, 32'h0);
        rd(5'd11, 32'h0, "cnt_compare_rd");
        // Compare write coinciding with a match: the clear must win.
        wr(5'd11, 32'd7);
        wr(5'd9, 32'd6);
        tick();
        wr(5'd11, 32'd9);
        check("cnt_clear_wins", {31'b0, bus.IntReq}, 32'h0);
        wr(5'd11, 32'd0);
`else
        tick();
        wr(5'd9, 32'h1234_5678);
        rd(5'd9, 32'h0, "nocnt_idx9");
        rd(5'd11, 32'h0, "nocnt_idx11");
`endif

        // mtc0 SR then a device interrupt: two-edge latency
        tick();
        bus.a = 5'd12; bus.din = 32'h0000_0401; bus.we = 1'b1;
        tick();
        bus.we = 1'b0; HWInt = 6'b000001;
        #1 check("lat_e0", {31'b0, bus.IntReq}, 32'h0);
        tick();
        check("lat_e1", {31'b0, bus.IntReq}, 32'h0);
        tick();
        check("lat_e2", {31'b0, bus.IntReq}, 32'h1);
        rd(5'd13, 32'h0000_0400, "cause_ip0");

        // Exception entry and eret held two cycles
        bus.EXLSet = 1'b1; bus.pc = 30'h0000_0C01;
        tick();
        bus.EXLSet = 1'b0;
        check("exc_epc", {2'b0, bus.epc}, 32'h0000_0C01);
        rd(5'd14, 32'h0000_3004, "exc_epc_rd");
        check("exc_intreq_off", {31'b0, bus.IntReq}, 32'h0);
        bus.EXLClr = 1'b1;
        tick();
        tick();
        bus.EXLClr = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_sr");
        check("eret_intreq_back", {31'b0, bus.IntReq}, 32'h1);

        // Same-edge priorities
        tick();
        bus.EXLSet = 1'b1; bus.EXLClr = 1'b1; bus.pc = 30'h0000_1234;
        tick();
        bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
        rd(5'd12, 32'h0000_0403, "set_over_clr");
        check("set_over_clr_epc", {2'b0, bus.epc}, 32'h0000_1234);
        tick();
        bus.EXLSet = 1'b1; bus.pc = 30'h0000_2AAA;
        bus.we = 1'b1; bus.a = 5'd14; bus.din = 32'hDEAD_BEEC;
        tick();
        bus.EXLSet = 1'b0; bus.we = 1'b0;
        check("set_over_mtc0_epc", {2'b0, bus.epc}, 32'h0000_2AAA);
        rd(5'd12, 32'h0000_0403, "set_over_mtc0_sr");
        tick();
        bus.EXLSet = 1'b1; bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'h0000_0800;
        tick();
        bus.EXLSet = 1'b0; bus.we = 1'b0;
        rd(5'd12, 32'h0000_0802, "set_over_sr_exl");
        tick();
        bus.EXLClr = 1'b1; bus.we = 1'b1; bus.a = 5'd12; bus.din = 32'h0000_0403;
        tick();
        bus.EXLClr = 1'b0; bus.we = 1'b0;
        rd(5'd12, 32'h0000_0403, "sr_over_clr");

        // Asynchronous reset mid-handler, checked without a clock edge
        bus.a = 5'd12;
        #1 rst = 1'b0;
        #1;
        check("arst_sr", bus.dout, 32'h0);
        check("arst_epc", {2'b0, bus.epc}, 32'h0);
        check("arst_intreq", {31'b0, bus.IntReq}, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] pick [7];
            pick = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'($urandom)};
            bus.a = pick[$urandom_range(6)];
            bus.we = ($urandom_range(3) == 0);
            bus.din = $urandom;
            if (bus.a == 5'd11 && $urandom_range(1) == 1) bus.din = m_count + 3;
            if (bus.a == 5'd12 && $urandom_range(1) == 1) bus.din[1:0] = 2'b01;
            bus.EXLSet = ($urandom_range(15) == 0);
            bus.EXLClr = ($urandom_range(7) == 0);
            bus.pc = 30'($urandom);
            if ($urandom_range(7) == 0) HWInt = 6'($urandom);
            tick();
        end
        bus.we = 1'b0; bus.EXLSet = 1'b0; bus.EXLClr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
